// File: rtl/paridade_pkg.sv
// Shared definitions for the streaming parity block: mode encodings, packet
// FSM state type and default widths.
package paridade_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int LEN_W_DEF = 8;

  typedef enum logic {
    S_IDLE,
    S_ACC
  } state_e;

endpackage

// File: rtl/paridade_calc.sv
// Combinational parity of one WIDTH-bit word. raw_o is the plain XOR of the
// bits, par_o is that value adjusted for even/odd mode.
module paridade_calc
  import paridade_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             odd_sel_i,
  output logic             raw_o,
  output logic             par_o
);

  assign raw_o = ^data_i;
  assign par_o = raw_o ^ (odd_sel_i == PAR_ODD);

endmodule

// File: rtl/paridade_stream.sv
// Streaming parity generator/checker with a single output register, packet
// level parity/length/error accumulation and a saturating error counter.
module paridade_stream
  import paridade_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             odd_sel,
  input  logic             chk_en,
  input  logic             clr_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_par,
  output logic             out_err,
  output logic             out_last,
  output logic             pkt_par,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_par_q, out_par_d;
  logic               out_err_q, out_err_d;
  logic               out_last_q, out_last_d;
  logic               acc_q, acc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               perr_q, perr_d;
  logic               pkt_par_q, pkt_par_d;
  logic [LEN_W-1:0]   pkt_len_q, pkt_len_d;
  logic               pkt_err_q, pkt_err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               word_raw, word_par, word_err, accept;
  logic               acc_nx, err_nx;
  logic [LEN_W-1:0]   len_base, len_nx;

  paridade_calc #(.WIDTH(WIDTH)) u_calc (
    .data_i    (in_data),
    .odd_sel_i (odd_sel),
    .raw_o     (word_raw),
    .par_o     (word_par)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign word_err = chk_en && (word_par != in_par);

  // In IDLE the accumulators are stale, so the first word starts from zero.
  assign acc_nx   = ((state_q == S_ACC) ? acc_q : 1'b0) ^ word_raw;
  assign err_nx   = ((state_q == S_ACC) && perr_q) || word_err;
  assign len_base = (state_q == S_ACC) ? len_q : '0;
  assign len_nx   = (len_base == LEN_MAX) ? LEN_MAX : len_base + LEN_W'(1);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_par_d   = out_par_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    acc_d       = acc_q;
    len_d       = len_q;
    perr_d      = perr_q;
    pkt_par_d   = pkt_par_q;
    pkt_len_d   = pkt_len_q;
    pkt_err_d   = pkt_err_q;
    err_cnt_d   = err_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_par_d   = word_par;
      out_err_d   = word_err;
      out_last_d  = in_last;
      if (in_last) begin
        state_d   = S_IDLE;
        pkt_par_d = acc_nx ^ (odd_sel == PAR_ODD);
        pkt_len_d = len_nx;
        pkt_err_d = err_nx;
      end else begin
        state_d = S_ACC;
        acc_d   = acc_nx;
        len_d   = len_nx;
        perr_d  = err_nx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear wins over a same-cycle increment.
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (accept && word_err && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_par_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      acc_q       <= 1'b0;
      len_q       <= '0;
      perr_q      <= 1'b0;
      pkt_par_q   <= 1'b0;
      pkt_len_q   <= '0;
      pkt_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_par_q   <= out_par_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      perr_q      <= perr_d;
      pkt_par_q   <= pkt_par_d;
      pkt_len_q   <= pkt_len_d;
      pkt_err_q   <= pkt_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_par   = out_par_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;
  assign pkt_par   = pkt_par_q;
  assign pkt_len   = pkt_len_q;
  assign pkt_err   = pkt_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
